// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampled 8N1 receiver with show-ahead byte FIFO and sticky error flags
module uart_rx_fifo #(
  parameter int CLOCK_DIV = 27,
  parameter int DEPTH     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rx_signal,
  input  logic                     read,
  input  logic                     clear_errors,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     framing_error,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(CLOCK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Line synchronizer and oversample tick
  // ---------------------------------------------------------------------------
  logic          sync_q;
  logic          rx_s_q;
  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          tick;

  // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      sync_q <= rx_signal;
      rx_s_q <= sync_q;
    end
  end

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Free-running divider producing one tick every CLOCK_DIV clocks
  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Deframing FSM
  // ---------------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] tc_q;
  logic [2:0] bi_q;
  logic [7:0] shift_q;
  logic       stop_hit;
  logic       push;
  logic       frame_err;

  // The stop bit is judged on the same tick edge that the FSM leaves STOP,
  // so the push and the framing flag land on that edge too.
  assign stop_hit  = tick && (state_q == S_STOP) && (tc_q == 4'd15);
  assign push      = stop_hit && rx_s_q;
  assign frame_err = stop_hit && !rx_s_q;

  // Frame sequencing: half a bit to mid-start, then a full bit to each data/stop centre
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tc_q    <= 4'd0;
      bi_q    <= 3'd0;
      shift_q <= 8'h00;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            tc_q    <= 4'd0;
          end
        end
        S_START: begin
          if (tc_q == 4'd7) begin
            tc_q <= 4'd0;
            bi_q <= 3'd0;
            // A line back high at mid-start was a glitch, not a character
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tc_q <= tc_q + 4'd1;
          end
        end
        S_DATA: begin
          if (tc_q == 4'd15) begin
            shift_q[bi_q] <= rx_s_q;
            tc_q          <= 4'd0;
            if (bi_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              bi_q <= bi_q + 3'd1;
            end
          end else begin
            tc_q <= tc_q + 4'd1;
          end
        end
        S_STOP: begin
          if (tc_q == 4'd15) begin
            tc_q    <= 4'd0;
            // A low stop bit may be a break; wait for the line to recover before hunting again
            state_q <= rx_s_q ? S_IDLE : S_WAIT_IDLE;
          end else begin
            tc_q <= tc_q + 4'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tc_q    <= 4'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          empty;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          overrun_evt;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop on the push cycle frees the slot, so a full FIFO can still accept the byte
  assign do_pop      = read && !empty;
  assign do_push     = push && (!full || do_pop);
  assign overrun_evt = push && full && !do_pop;

  assign wr_ptr_d = wr_ptr_q + AW'(do_push);
  assign rd_ptr_d = rd_ptr_q + AW'(do_pop);
  assign count_d  = count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);

  // Byte storage; no reset needed because the output is gated while empty
  always_ff @(posedge clock) begin
    if (!reset && do_push) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sticky error flags; a new error on the clearing cycle keeps the flag set
  always_ff @(posedge clock) begin
    if (reset) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (frame_err) begin
        framing_error <= 1'b1;
      end else if (clear_errors) begin
        framing_error <= 1'b0;
      end
      if (overrun_evt) begin
        overrun <= 1'b1;
      end else if (clear_errors) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rx_valid = !empty;
  assign rx_count = count_q;
  assign rx_data  = empty ? 8'h00 : mem[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int CLOCK_DIV = 4;
  localparam int DEPTH     = 8;
  localparam int BITLEN    = 16 * CLOCK_DIV;
  localparam int FRAMELEN  = 10 * BITLEN;
  // Clock offset within a tick-aligned frame on which the stop-bit push edge is sampled
  localparam int PUSH_C    = 610;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_signal = 1'b1;
  logic       read = 1'b0;
  logic       clear_errors = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  uart_rx_fifo #(.CLOCK_DIV(CLOCK_DIV), .DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .rx_signal(rx_signal),
    .read(read),
    .clear_errors(clear_errors),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_count(rx_count),
    .framing_error(framing_error),
    .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Edges since the last reset edge; the DUT divider ticks on edges where this is a multiple of 4
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_signal = 1'b1; read = 1'b0; clear_errors = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic hold(input logic level, input int n);
    rx_signal = level;
    repeat (n) step();
  endtask

  task automatic pulse_read();
    read = 1'b1; step(); read = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1; step(); clear_errors = 1'b0;
  endtask

  // One 8N1 frame starting just after an edge with cyc%4==1; side strobes at given clock offsets
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int pop_at, input int clr_at, input int rst_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    while (cyc % 4 != 1) step();
    for (int c = 0; c < FRAMELEN; c++) begin
      rx_signal    = bits[c / BITLEN];
      read         = (c == pop_at);
      clear_errors = (c == clr_at);
      reset        = (c == rst_at);
      step();
    end
    read = 1'b0; clear_errors = 1'b0; reset = 1'b0; rx_signal = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
    checks++; if (rx_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", rx_count); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {framing_error, overrun}); end
  endtask

  task automatic test_two_bytes();
    send_frame(8'h55, 1'b1, -1, -1, -1);
    send_frame(8'hA3, 1'b1, -1, -1, -1);
    checks++; if (rx_count !== 4'd2) begin failures++; $display("FAIL two_count got=%0d exp=2", rx_count); end
    checks++; if (rx_data !== 8'h55) begin failures++; $display("FAIL two_head got=%h exp=55", rx_data); end
    pulse_read();
    checks++; if (rx_data !== 8'hA3) begin failures++; $display("FAIL two_second got=%h exp=a3", rx_data); end
    checks++; if (rx_count !== 4'd1) begin failures++; $display("FAIL two_count_pop got=%0d exp=1", rx_count); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin failures++; $display("FAIL two_flags got=%b exp=00", {framing_error, overrun}); end
    pulse_read();
    pulse_read();
    checks++; if (rx_count !== 4'd0 || rx_valid !== 1'b0) begin failures++; $display("FAIL empty_read got=%0d/%0b exp=0/0", rx_count, rx_valid); end
  endtask

  task automatic test_glitch();
    while (cyc % 4 != 1) step();
    hold(1'b0, 16);
    hold(1'b1, 200);
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL glitch_valid got=%0b exp=0", rx_valid); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin failures++; $display("FAIL glitch_flags got=%b exp=00", {framing_error, overrun}); end
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    hold(1'b0, 3 * BITLEN);
    hold(1'b1, BITLEN);
    send_frame(8'h7E, 1'b1, -1, -1, -1);
    checks++; if (framing_error !== 1'b1) begin failures++; $display("FAIL frame_flag got=%0b exp=1", framing_error); end
    checks++; if (rx_count !== 4'd1) begin failures++; $display("FAIL frame_count got=%0d exp=1", rx_count); end
    checks++; if (rx_data !== 8'h7E) begin failures++; $display("FAIL frame_data got=%h exp=7e", rx_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL frame_overrun got=%0b exp=0", overrun); end
    pulse_clear();
    checks++; if (framing_error !== 1'b0) begin failures++; $display("FAIL frame_clear got=%0b exp=0", framing_error); end
    pulse_read();
  endtask

  task automatic test_overrun();
    do_reset();
    // Ninth byte is dropped; clear_errors on that same edge must lose to the new overrun
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, -1, (i == 9) ? PUSH_C : -1, -1);
    checks++; if (rx_count !== 4'd8) begin failures++; $display("FAIL ovr_count got=%0d exp=8", rx_count); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0b exp=1", overrun); end
    for (int i = 1; i <= 8; i++) begin
      checks++; if (rx_data !== 8'(i)) begin failures++; $display("FAIL ovr_data%0d got=%h exp=%h", i, rx_data, 8'(i)); end
      pulse_read();
    end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ovr_drained got=%0b exp=0", rx_valid); end
    pulse_clear();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%0b exp=0", overrun); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [$];
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, -1, -1, -1);
    send_frame(8'h99, 1'b1, PUSH_C, -1, -1);
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h99};
    checks++; if (rx_count !== 4'd8) begin failures++; $display("FAIL pp_count got=%0d exp=8", rx_count); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL pp_overrun got=%0b exp=0", overrun); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (rx_data !== exp_q[i]) begin failures++; $display("FAIL pp_data%0d got=%h exp=%h", i, rx_data, exp_q[i]); end
      pulse_read();
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    // Reset lands inside data bit 4; bits 4..7 and stop are high so the line just idles afterwards
    send_frame(8'hF5, 1'b1, -1, -1, 5 * BITLEN + 30);
    checks++; if (rx_valid !== 1'b0 || rx_count !== 4'd0) begin failures++; $display("FAIL rst_fifo got=%0b/%0d exp=0/0", rx_valid, rx_count); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", rx_data); end
    checks++; if ({framing_error, overrun} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {framing_error, overrun}); end
    send_frame(8'h81, 1'b1, -1, -1, -1);
    checks++; if (rx_count !== 4'd1) begin failures++; $display("FAIL rst_rx_count got=%0d exp=1", rx_count); end
    checks++; if (rx_data !== 8'h81) begin failures++; $display("FAIL rst_rx_data got=%h exp=81", rx_data); end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_glitch();
    test_framing();
    test_overrun();
    test_push_pop_full();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front-end for the memory-mapped UART peripherals on the processor data bus. It samples the asynchronous `rx_signal` line at 16x oversampling and deframes 8N1 characters, LSB first. Received bytes are queued in a show-ahead FIFO, and framing and overrun errors are flagged. The register-mapped UART wrapper consumes `rx_data`, `rx_valid` and `rx_count` on a processor read and pops one byte per `read` strobe.

## Interface
- `CLOCK_DIV`, default 27: clock cycles per oversample tick (bit period = 16*CLOCK_DIV clocks); legal values ≥ 2.
- `DEPTH`, default 8: FIFO entries; must be a power of 2, ≥ 2.
- `clock`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `rx_signal`  in  1  asynchronous serial line, idle high.
- `read`  in  1  pop strobe; one byte popped per cycle high while `rx_valid`=1.
- `clear_errors`  in  1  clears `framing_error` and `overrun` sticky flags.
- `rx_data`  out  8  head-of-FIFO byte; valid only when `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `framing_error`  out  1  sticky: stop bit sampled low.
- `overrun`  out  1  sticky: a complete byte was dropped because the FIFO was full.

## Operation
- Synchronizer: two flops on `rx_signal`, both reset to 1. All FSM decisions use the second flop (`rx_s`).
- Tick divider:
  - Free-running counter, reset 0.
  - `tick` is asserted for one cycle when the counter equals CLOCK_DIV-1, then the counter wraps to 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Reset state is IDLE. A 4-bit tick counter `tc` and a 3-bit bit index `bi` advance only on `tick`.
- IDLE: on a tick with `rx_s`=0, go to START with `tc`=0.
- START: when `tc` reaches 7 (mid-start-bit):
  - `rx_s`=0 → go to DATA with `tc`=0, `bi`=0.
  - `rx_s`=1 → glitch; return to IDLE, nothing recorded.
- DATA:
  - When `tc` reaches 15, shift `rx_s` into `shift[bi]` (LSB first) and reset `tc`.
  - After `bi`=7 is sampled, go to STOP.
- STOP: when `tc` reaches 15, sample the stop bit.
  - `rx_s`=1 → push `shift` and go to IDLE.
  - `rx_s`=0 → set `framing_error`, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE: stay until a tick sees `rx_s`=1, then go to IDLE. This prevents a break condition from being read as back-to-back start bits.
- FIFO:
  - Write/read pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter.
  - `rx_data` = mem[rd_ptr] (show-ahead).
- Push when full and no pop in the same cycle: byte dropped, `overrun` set, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Not empty (including full): both happen and `rx_count` is unchanged; no overrun.
  - Empty: the pop is ignored and the push occurs.
- `read` while empty: ignored; no state change.
- `clear_errors` and an error event in the same cycle: the error wins and the flag stays 1.
- Reset mid-frame:
  - FSM returns to IDLE; FIFO is emptied; flags are cleared.
  - The partial byte is lost. The line is re-acquired on the next falling edge seen after reset.

## Timing
- Reset values:
  - Outputs: `rx_valid`=0, `rx_count`=0, `framing_error`=0, `overrun`=0, `rx_data`=0 (memory cleared or read gated to 0).
  - Internal: synchronizer flops=1, divider=0.
- Input latency: a `rx_signal` edge reaches `rx_s` 2 clocks later.
- Start detection is quantized to ticks: up to CLOCK_DIV clocks of jitter; the data sample point is within ±1/16 bit of mid-bit.
- Push latency: the byte is written on the clock edge of the stop-bit tick. `rx_valid`, `rx_count` and `rx_data` update on that same edge and are visible from the next cycle.
- Pop: `read` sampled on edge N; `rx_data` shows the next entry and `rx_count` decrements after edge N. This gives one byte per cycle of sustained drain.
- `framing_error` and `overrun` are set on the edge of the stop-bit tick.
- Throughput: one character per 160 ticks (start + 8 data + stop, since the FSM returns to IDLE at mid-stop-bit). Back-to-back frames at nominal baud are received without loss.

## Test plan
- CLOCK_DIV=4, DEPTH=8. Send 0x55, then 0xA3 at 64 clocks/bit. → `rx_count`=2, `rx_data`=0x55. After one `read`: `rx_data`=0xA3, `rx_count`=1. No flags.
- Drive `rx_signal` low for 16 clocks only (4 ticks), then high. → FSM returns to IDLE; `rx_valid` stays 0; no flags.
- Send 0x3C with the stop bit driven 0, hold low for 3 bit-times, then send 0x7E. → `framing_error`=1, 0x3C not queued, 0x7E received with `rx_count`=1. Pulse `clear_errors` → `framing_error`=0.
- Send 0x01–0x09 with no reads. → `rx_count`=8, `overrun`=1; reads return 0x01..0x08, then `rx_valid`=0.
- Fill to 8, then assert `read` on the exact cycle of the 9th byte's push. → `rx_count` stays 8, `overrun`=0, and the last entry is the 9th byte.
- Assert `reset` for 1 cycle mid-way through DATA bit 4, then send 0x81. → All outputs return to reset values, the partial byte is not queued, and 0x81 is received correctly.
